// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver with 3-sample majority voting and error flags
module uart_rx_cfg #(
    parameter int ClkFreq    = 10_000_000,
    parameter int BaudRate   = 115200,
    parameter int DataBits   = 8,
    parameter int ParityMode = 0,
    parameter int StopBits   = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_rx,
    output logic                o_rx_valid,
    input  logic                i_rx_ready,
    output logic [DataBits-1:0] o_rx_data,
    output logic                o_parity_err,
    output logic                o_frame_err,
    output logic                o_overrun,
    output logic                o_break
);

    localparam int BaudsPerBit = ClkFreq / BaudRate;
    localparam int H           = BaudsPerBit / 2;
    localparam int CntW        = $clog2(BaudsPerBit);
    localparam int IdxW        = $clog2(DataBits);

    if (BaudsPerBit < 8) begin : g_bad_baud
        $error("uart_rx_cfg: ClkFreq/BaudRate must be at least 8");
    end
    if (DataBits < 5 || DataBits > 9) begin : g_bad_width
        $error("uart_rx_cfg: DataBits must be in 5..9");
    end
    if (ParityMode < 0 || ParityMode > 2) begin : g_bad_parity
        $error("uart_rx_cfg: ParityMode must be 0, 1 or 2");
    end
    if (StopBits < 1 || StopBits > 2) begin : g_bad_stop
        $error("uart_rx_cfg: StopBits must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                sync1;
    logic                rx_s;
    logic                rx_prev;
    logic [CntW-1:0]     cnt;
    logic [IdxW-1:0]     idx;
    logic [DataBits-1:0] shreg;
    logic                samp_a;
    logic                samp_b;
    logic                par_bit;
    logic                stop1_bit;
    logic                stop_err;

    logic start_edge;
    logic wrap;
    logic vote_now;
    logic vote;
    logic last_bit;
    logic par_calc;
    logic par_err;
    logic brk_cond;

    assign start_edge = rx_prev & ~rx_s;
    assign wrap       = (cnt == CntW'(BaudsPerBit - 1));
    assign vote_now   = (cnt == CntW'(H + 1));
    // Third sample is the live synchronised line on the H+1 cycle.
    assign vote       = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
    assign last_bit   = (idx == IdxW'(DataBits - 1));
    assign par_calc   = (^shreg) ^ par_bit;
    assign par_err    = (ParityMode == 1) ? par_calc :
                        (ParityMode == 2) ? ~par_calc : 1'b0;
    assign brk_cond   = (shreg == '0) && ((ParityMode == 0) || !par_bit) && !stop1_bit;

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= i_rx;
            rx_s    <= sync1;
            rx_prev <= rx_s;
        end
    end

    // Frame state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame sequencing: bit boundaries on counter wrap, decisions on the vote cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start_edge) state_nxt = S_START;
            S_START: begin
                if (vote_now && vote) state_nxt = S_IDLE;
                else if (wrap)        state_nxt = S_DATA;
            end
            S_DATA:   if (wrap && last_bit) state_nxt = (ParityMode != 0) ? S_PARITY : S_STOP1;
            S_PARITY: if (wrap) state_nxt = S_STOP1;
            S_STOP1: begin
                if (StopBits == 1) begin
                    if (vote_now) state_nxt = S_DONE;
                end else if (wrap) begin
                    state_nxt = S_STOP2;
                end
            end
            S_STOP2:  if (vote_now) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Baud counter, vote samples and per-frame capture of data, parity and stop bits.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            samp_a    <= 1'b1;
            samp_b    <= 1'b1;
            par_bit   <= 1'b0;
            stop1_bit <= 1'b1;
            stop_err  <= 1'b0;
        end else begin
            if (state == S_IDLE) cnt <= '0;
            else                 cnt <= wrap ? '0 : cnt + CntW'(1);
            if (cnt == CntW'(H - 1)) samp_a <= rx_s;
            if (cnt == CntW'(H))     samp_b <= rx_s;
            case (state)
                S_IDLE: begin
                    idx      <= '0;
                    stop_err <= 1'b0;
                end
                S_DATA: begin
                    // LSB arrives first, so after DataBits shifts bit 0 holds the first data bit.
                    if (vote_now) shreg <= {vote, shreg[DataBits-1:1]};
                    if (wrap)     idx   <= idx + IdxW'(1);
                end
                S_PARITY: if (vote_now) par_bit <= vote;
                S_STOP1: begin
                    if (vote_now) begin
                        stop1_bit <= vote;
                        if (!vote) stop_err <= 1'b1;
                    end
                end
                S_STOP2: if (vote_now && !vote) stop_err <= 1'b1;
                default: ;
            endcase
        end
    end

    // Holding register with break/overrun arbitration and valid/ready handshake.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_rx_valid   <= 1'b0;
            o_rx_data    <= '0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
            o_break      <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            o_break   <= 1'b0;
            if (o_rx_valid && i_rx_ready) o_rx_valid <= 1'b0;
            if (state == S_DONE) begin
                if (brk_cond) begin
                    o_break <= 1'b1;
                end else if (o_rx_valid && !i_rx_ready) begin
                    o_overrun <= 1'b1;
                end else begin
                    o_rx_valid   <= 1'b1;
                    o_rx_data    <= shreg;
                    o_parity_err <= par_err;
                    o_frame_err  <= stop_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - self-checking bench for uart_rx_cfg across three configurations
module tb_uart_rx_cfg;

    localparam int BPB1 = 86;
    localparam int BPB2 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rx1, rx2, rx3;
    logic rdy1, rdy2, rdy3;
    logic v1, pe1, fe1, ov1, bk1;
    logic v2, pe2, fe2, ov2, bk2;
    logic v3, pe3, fe3, ov3, bk3;
    logic [7:0] d1;
    logic [6:0] d2;
    logic [6:0] d3;

    int errors = 0;
    int checks = 0;
    int ov1_n = 0, ov2_n = 0, ov3_n = 0;
    int bk1_n = 0, bk2_n = 0, bk3_n = 0;
    logic [17:0] q1[$];
    logic [17:0] q2[$];
    logic [17:0] q3[$];

    uart_rx_cfg u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx1), .o_rx_valid(v1), .i_rx_ready(rdy1),
        .o_rx_data(d1), .o_parity_err(pe1), .o_frame_err(fe1), .o_overrun(ov1), .o_break(bk1)
    );

    uart_rx_cfg #(.ClkFreq(1_600_000), .BaudRate(100_000), .DataBits(7), .ParityMode(1), .StopBits(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx2), .o_rx_valid(v2), .i_rx_ready(rdy2),
        .o_rx_data(d2), .o_parity_err(pe2), .o_frame_err(fe2), .o_overrun(ov2), .o_break(bk2)
    );

    uart_rx_cfg #(.ClkFreq(1_600_000), .BaudRate(100_000), .DataBits(7), .ParityMode(2), .StopBits(2)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx3), .o_rx_valid(v3), .i_rx_ready(rdy3),
        .o_rx_data(d3), .o_parity_err(pe3), .o_frame_err(fe3), .o_overrun(ov3), .o_break(bk3)
    );

    // Accepted frames and event pulses, sampled mid-cycle.
    always @(negedge clk) begin
        #1;
        if (v1 && rdy1) q1.push_back({pe1, fe1, 8'd0, d1});
        if (v2 && rdy2) q2.push_back({pe2, fe2, 9'd0, d2});
        if (v3 && rdy3) q3.push_back({pe3, fe3, 9'd0, d3});
        if (ov1) ov1_n++;
        if (ov2) ov2_n++;
        if (ov3) ov3_n++;
        if (bk1) bk1_n++;
        if (bk2) bk2_n++;
        if (bk3) bk3_n++;
    end

    // Expected outcome of one frame: {break, parity_err, frame_err, data}.
    function automatic logic [18:0] model(input int mode, input int nstop, input logic [8:0] data,
                                          input logic pbit, input logic s1, input logic s2);
        int   ones;
        logic pe, fe, brk;
        ones = $countones(data);
        if (mode == 0)      pe = 1'b0;
        else if (mode == 1) pe = ((ones + int'(pbit)) % 2) != 0;
        else                pe = ((ones + int'(pbit)) % 2) == 0;
        fe  = !s1 || (nstop == 2 && !s2);
        brk = (ones == 0) && (mode == 0 || !pbit) && !s1;
        return {brk, pe, fe, 7'd0, data};
    endfunction

    task automatic set_line(input int inst, input logic val);
        case (inst)
            1: rx1 = val;
            2: rx2 = val;
            default: rx3 = val;
        endcase
    endtask

    // Drives one frame; spike selects a frame bit (0 = start) that gets a 1-cycle high mid-bit.
    task automatic send_frame(input int inst, input logic [8:0] data, input int nd, input int npar,
                              input logic pbit, input int nstop, input logic s1, input logic s2,
                              input int spike, input int gap);
        logic bits[16];
        int   n;
        int   bpb;
        bpb = (inst == 1) ? BPB1 : BPB2;
        bits[0] = 1'b0;
        n = 1;
        for (int i = 0; i < nd; i++) begin
            bits[n] = data[i];
            n++;
        end
        if (npar != 0) begin
            bits[n] = pbit;
            n++;
        end
        bits[n] = s1;
        n++;
        if (nstop == 2) begin
            bits[n] = s2;
            n++;
        end
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < bpb; j++) begin
                set_line(inst, (i == spike && j == bpb / 2) ? 1'b1 : bits[i]);
                @(negedge clk);
            end
        end
        set_line(inst, 1'b1);
        repeat (gap * bpb) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (v1 !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %b expected 0", v1); end
        checks++; if (d1 !== 8'h00)  begin errors++; $display("FAIL reset_data: got %h expected 00", d1); end
        checks++; if (pe1 !== 1'b0)  begin errors++; $display("FAIL reset_parity: got %b expected 0", pe1); end
        checks++; if (fe1 !== 1'b0)  begin errors++; $display("FAIL reset_frame: got %b expected 0", fe1); end
        checks++; if (ov1 !== 1'b0)  begin errors++; $display("FAIL reset_overrun: got %b expected 0", ov1); end
        checks++; if (bk1 !== 1'b0)  begin errors++; $display("FAIL reset_break: got %b expected 0", bk1); end
        checks++; if ({v2, v3} !== 2'b00) begin errors++; $display("FAIL reset_valid_cfg: got %b expected 00", {v2, v3}); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_default_frame;
        logic [18:0] exp;
        logic [17:0] got;
        exp = model(0, 1, 9'h0A5, 1'b0, 1'b1, 1'b1);
        send_frame(1, 9'h0A5, 8, 0, 1'b0, 1, 1'b1, 1'b1, -1, 2);
        checks++;
        if (q1.size() != 1) begin
            errors++; $display("FAIL default_count: got %0d frames expected 1", q1.size());
        end else begin
            got = q1.pop_front();
            checks++;
            if (got !== exp[17:0]) begin errors++; $display("FAIL default_frame: got %h expected %h", got, exp[17:0]); end
        end
        checks++;
        if (ov1_n != 0 || bk1_n != 0) begin errors++; $display("FAIL default_events: got ovr=%0d brk=%0d expected 0 0", ov1_n, bk1_n); end
    endtask

    task automatic test_parity;
        logic [18:0] exp;
        logic [17:0] got;
        int          qsz;
        for (int inst = 2; inst <= 3; inst++) begin
            for (int pb = 0; pb < 2; pb++) begin
                exp = model(inst - 1, 2, 9'h035, pb[0], 1'b1, 1'b1);
                send_frame(inst, 9'h035, 7, 1, pb[0], 2, 1'b1, 1'b1, -1, 2);
                got = '0;
                if (inst == 2) begin qsz = q2.size(); if (qsz > 0) got = q2.pop_front(); end
                else           begin qsz = q3.size(); if (qsz > 0) got = q3.pop_front(); end
                checks++;
                if (qsz != 1) begin
                    errors++; $display("FAIL parity_count inst%0d pbit%0d: got %0d expected 1", inst, pb, qsz);
                end
                checks++;
                if (got !== exp[17:0]) begin
                    errors++; $display("FAIL parity_frame inst%0d pbit%0d: got %h expected %h", inst, pb, got, exp[17:0]);
                end
            end
        end
    endtask

    task automatic test_glitch;
        logic [17:0] got;
        set_line(1, 1'b0);
        @(negedge clk);
        set_line(1, 1'b1);
        repeat (3 * BPB1) @(negedge clk);
        checks++;
        if (q1.size() != 0 || v1 !== 1'b0) begin
            errors++; $display("FAIL glitch_start: got %0d frames valid=%b expected 0 0", q1.size(), v1);
            q1.delete();
        end
        send_frame(1, 9'h000, 8, 0, 1'b0, 1, 1'b1, 1'b1, 4, 2);
        checks++;
        if (q1.size() != 1) begin
            errors++; $display("FAIL glitch_count: got %0d frames expected 1", q1.size());
        end else begin
            got = q1.pop_front();
            checks++;
            if (got !== 18'h0) begin errors++; $display("FAIL glitch_vote: got %h expected 00000", got); end
        end
    endtask

    task automatic test_frame_break;
        logic [18:0] exp;
        logic [17:0] got;
        int          b0;
        exp = model(0, 1, 9'h03C, 1'b0, 1'b0, 1'b1);
        send_frame(1, 9'h03C, 8, 0, 1'b0, 1, 1'b0, 1'b1, -1, 2);
        checks++;
        if (q1.size() != 1) begin
            errors++; $display("FAIL frame_err_count: got %0d frames expected 1", q1.size());
        end else begin
            got = q1.pop_front();
            checks++;
            if (got !== exp[17:0]) begin errors++; $display("FAIL frame_err: got %h expected %h", got, exp[17:0]); end
        end
        b0 = bk1_n;
        send_frame(1, 9'h000, 8, 0, 1'b0, 1, 1'b0, 1'b1, -1, 2);
        checks++;
        if (bk1_n != b0 + 1) begin errors++; $display("FAIL break_pulse: got %0d expected %0d", bk1_n, b0 + 1); end
        checks++;
        if (q1.size() != 0 || v1 !== 1'b0) begin
            errors++; $display("FAIL break_hold: got %0d frames valid=%b expected 0 0", q1.size(), v1);
            q1.delete();
        end
    endtask

    task automatic test_back_to_back;
        logic [17:0] got;
        int          o0;
        rdy1 = 1'b0;
        o0 = ov1_n;
        send_frame(1, 9'h011, 8, 0, 1'b0, 1, 1'b1, 1'b1, -1, 0);
        send_frame(1, 9'h022, 8, 0, 1'b0, 1, 1'b1, 1'b1, -1, 2);
        checks++;
        if (v1 !== 1'b1 || d1 !== 8'h11) begin
            errors++; $display("FAIL overrun_hold: got valid=%b data=%h expected 1 11", v1, d1);
        end
        checks++;
        if (ov1_n != o0 + 1) begin errors++; $display("FAIL overrun_pulse: got %0d expected %0d", ov1_n, o0 + 1); end
        rdy1 = 1'b1;
        @(negedge clk);
        checks++;
        if (v1 !== 1'b0) begin errors++; $display("FAIL accept_clear: got %b expected 0", v1); end
        checks++;
        if (q1.size() != 1) begin
            errors++; $display("FAIL accept_count: got %0d expected 1", q1.size());
        end else begin
            got = q1.pop_front();
            checks++;
            if (got !== 18'h00011) begin errors++; $display("FAIL accept_data: got %h expected 00011", got); end
        end
    endtask

    task automatic test_reset_midframe;
        logic [7:0]  c;
        logic [17:0] got;
        c = 8'hC3;
        rdy1 = 1'b0;
        send_frame(1, 9'h077, 8, 0, 1'b0, 1, 1'b1, 1'b1, -1, 2);
        checks++;
        if (v1 !== 1'b1 || d1 !== 8'h77) begin errors++; $display("FAIL pre_reset_hold: got valid=%b data=%h expected 1 77", v1, d1); end
        set_line(1, 1'b0);
        repeat (BPB1) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            set_line(1, c[i]);
            repeat (BPB1) @(negedge clk);
        end
        set_line(1, c[4]);
        repeat (BPB1 / 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({v1, pe1, fe1, ov1, bk1} !== 5'b0 || d1 !== 8'h00) begin
            errors++; $display("FAIL midframe_reset: got flags=%b data=%h expected 00000 00", {v1, pe1, fe1, ov1, bk1}, d1);
        end
        rst_n = 1'b1;
        set_line(1, 1'b1);
        rdy1 = 1'b1;
        repeat (12 * BPB1) @(negedge clk);
        checks++;
        if (q1.size() != 0) begin errors++; $display("FAIL abort_silent: got %0d frames expected 0", q1.size()); q1.delete(); end
        send_frame(1, 9'h05A, 8, 0, 1'b0, 1, 1'b1, 1'b1, -1, 2);
        checks++;
        if (q1.size() != 1) begin
            errors++; $display("FAIL post_reset_count: got %0d expected 1", q1.size());
        end else begin
            got = q1.pop_front();
            checks++;
            if (got !== 18'h0005A) begin errors++; $display("FAIL post_reset_data: got %h expected 0005a", got); end
        end
    endtask

    task automatic test_random;
        logic [8:0]  data;
        logic        pbit, s1, s2;
        logic [18:0] exp;
        logic [17:0] got;
        int          qsz, bk0, bk_now, ones;
        for (int k = 0; k < 24; k++) begin
            int inst;
            inst = (k < 6) ? 1 : (k < 15) ? 2 : 3;
            if (inst == 1) data = 9'($urandom_range(0, 255));
            else           data = ($urandom_range(0, 3) == 0) ? 9'h000 : 9'($urandom_range(0, 127));
            ones = $countones(data);
            s1 = ($urandom_range(0, 3) != 0);
            s2 = (inst == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
            pbit = (inst == 3) ? ((ones % 2) == 0) : ((ones % 2) != 0);
            if (inst != 1 && $urandom_range(0, 2) == 0) pbit = ~pbit;
            if (inst == 1) pbit = 1'b0;
            exp = model(inst - 1, (inst == 1) ? 1 : 2, data, pbit, s1, s2);
            case (inst)
                1:       bk0 = bk1_n;
                2:       bk0 = bk2_n;
                default: bk0 = bk3_n;
            endcase
            if (inst == 1) send_frame(1, data, 8, 0, 1'b0, 1, s1, 1'b1, -1, 2);
            else           send_frame(inst, data, 7, 1, pbit, 2, s1, s2, -1, 2);
            got = '0;
            case (inst)
                1:       begin qsz = q1.size(); if (qsz > 0) got = q1.pop_front(); bk_now = bk1_n; end
                2:       begin qsz = q2.size(); if (qsz > 0) got = q2.pop_front(); bk_now = bk2_n; end
                default: begin qsz = q3.size(); if (qsz > 0) got = q3.pop_front(); bk_now = bk3_n; end
            endcase
            checks++;
            if (bk_now != bk0 + int'(exp[18])) begin
                errors++; $display("FAIL rand_break k%0d inst%0d: got %0d expected %0d", k, inst, bk_now - bk0, exp[18]);
            end
            checks++;
            if (qsz != (exp[18] ? 0 : 1)) begin
                errors++; $display("FAIL rand_count k%0d inst%0d: got %0d expected %0d", k, inst, qsz, exp[18] ? 0 : 1);
            end else if (!exp[18]) begin
                checks++;
                if (got !== exp[17:0]) begin
                    errors++; $display("FAIL rand_frame k%0d inst%0d: got %h expected %h", k, inst, got, exp[17:0]);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rx1 = 1'b1; rx2 = 1'b1; rx3 = 1'b1;
        rdy1 = 1'b1; rdy2 = 1'b1; rdy3 = 1'b1;
        @(negedge clk);
        test_reset;
        test_default_frame;
        test_parity;
        test_glitch;
        test_frame_break;
        test_back_to_back;
        test_reset_midframe;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver. Configurable data width, parity and stop-bit count. Uses 3-sample majority voting per bit and flags framing, parity, overrun and break conditions. Sits between the pad-side rx line and a consumer; output uses a valid/ready handshake with a one-entry holding register.

Parameters:
ClkFreq, 10_000_000, system clock frequency in Hz.
BaudRate, 115200, line rate in bit/s. BaudsPerBit = ClkFreq/BaudRate, which must be >= 8 (elaboration error otherwise).
DataBits, 8, data bits per frame, legal range 5..9.
ParityMode, 0, 0 = none, 1 = even, 2 = odd.
StopBits, 1, stop bits checked, 1 or 2.

Ports:
i_clk  input  1  system clock.
i_rst_n  input  1  synchronous active-low reset.
i_rx  input  1  asynchronous serial line, idle high.
o_rx_valid  output  1  holding register contains an unread frame.
i_rx_ready  input  1  consumer accepts the frame when o_rx_valid && i_rx_ready.
o_rx_data  output  DataBits  received data, LSB first on the line. Bit 0 is the first data bit.
o_parity_err  output  1  parity mismatch for the held frame; always 0 when ParityMode = 0.
o_frame_err  output  1  a stop-bit vote was 0 for the held frame.
o_overrun  output  1  single-cycle pulse: a frame completed while the holding register was full and not being read. The new frame is dropped.
o_break  output  1  single-cycle pulse: all data bits, the parity bit (if present) and the first stop bit were voted 0.

Behaviour:
- Sync and reset
  - i_rx passes through a 2-flop synchroniser; call the result rx_s.
  - All logic updates only on the i_clk rising edge.
  - Reset (i_rst_n = 0 at an edge): synchroniser flops set to 1, FSM goes to IDLE, counters cleared.
  - All outputs reset to 0: o_rx_valid, o_rx_data, o_parity_err, o_frame_err, o_overrun, o_break.
  - Reset mid-frame aborts the frame silently.
- Timing
  - Baud counter runs 0..BaudsPerBit-1 and wraps. It restarts at 0 on start-edge detection.
  - Let H = BaudsPerBit/2 (integer division).
  - Each bit is sampled at counter values H-1, H and H+1. Bit value = majority of the 3 samples, resolved on the H+1 cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, DONE.
  - IDLE: on a falling edge of rx_s (previous 1, current 0), go to START and clear the counter.
  - START: if the start vote is 1 (false start/glitch), return to IDLE with no outputs. Otherwise go to DATA at counter wrap with bit index 0.
  - DATA: shift the vote into bit [index]. After bit DataBits-1, go to PARITY if ParityMode != 0, else STOP1.
  - PARITY: compare the vote with the computed parity. Even: XOR of data ^ parity bit must be 0. Odd: must be 1.
  - STOP1: on the vote, go directly to DONE (StopBits = 1) or wait for wrap and go to STOP2. No wait for the end of the stop bit, so back-to-back frames are supported.
  - STOP2: vote, then go to DONE.
  - DONE: single cycle, then IDLE. A falling edge in the DONE cycle itself is missed; the line is guaranteed high at that point for a legal frame.
- Delivery (in DONE)
  - Break: if the break condition holds, pulse o_break; the holding register is unchanged.
  - Else, if o_rx_valid && !i_rx_ready: pulse o_overrun; old contents are kept.
  - Else: load o_rx_data, o_parity_err and o_frame_err, and set o_rx_valid. A frame with errors is still delivered, with its flags set.
- Handshake
  - o_rx_valid clears on the cycle after an accept.
  - Accept and load in the same cycle: the load wins, and o_rx_valid stays 1.
  - o_rx_data and the flags are stable while o_rx_valid = 1.
- Latency: o_rx_valid rises 2 cycles after the H+1 sample of the final stop bit. This is 1 cycle for the DONE state plus the register stage; synchroniser delay is excluded.
- DataBits = 9: the full 9-bit word is delivered, with no special address handling.

Test Plan:
1. Defaults (8N1, BaudsPerBit = 86). Send 0xA5, i_rx_ready = 1 -> one-cycle o_rx_valid, o_rx_data = 0xA5, all flags 0.
2. DataBits = 7, ParityMode = 1, StopBits = 2. Send 0x35 with the correct parity (0), then 0x35 with the parity bit flipped -> first frame has o_parity_err = 0, second has o_parity_err = 1 with data 0x35. Repeat with ParityMode = 2 and confirm the inverted expectation.
3. Glitch tolerance:
   - 1-cycle low pulse on an idle line -> no o_rx_valid.
   - 1-cycle high spike at the mid-sample of data bit 3 of 0x00 -> data 0x00 via majority vote.
4. Send 0x3C with the stop bit held low for one bit time, then the line returns high -> o_rx_data = 0x3C, o_frame_err = 1. Then send all-zero data plus a zero stop bit -> o_break pulse, o_rx_valid unchanged.
5. Hold i_rx_ready = 0 and send 0x11 then 0x22 back-to-back -> o_rx_data = 0x11 retained, o_overrun pulses once at the second DONE. Raise i_rx_ready -> o_rx_valid falls the next cycle.
6. Assert i_rst_n = 0 for 1 cycle during data bit 4 -> all outputs 0. A subsequent clean 0x5A is received correctly.
